// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one uart_tx serializer among NUM_REQ byte streams.
// Build with UART_ARB_TIMEOUT_EN defined to drop a lock that idles TIMEOUT_CLKS cycles inside a packet.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned TIMEOUT_CLKS = 270000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [8*NUM_REQ-1:0]   req_data,
   input  logic [NUM_REQ-1:0]     req_last,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [NUM_REQ-1:0]     grant,
   output logic                   tx_start,
   output logic [7:0]             tx_data,
   input  logic                   tx_busy,
   output logic                   timeout_pulse
);

   localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [1:0] ARB       = 2'd0;
   localparam logic [1:0] LAUNCH    = 2'd1;
   localparam logic [1:0] WAIT_BUSY = 2'd2;
   localparam logic [1:0] WAIT_DONE = 2'd3;

   logic [1:0]         state, state_d;
   logic [NUM_REQ-1:0] grant_d;
   logic [PW-1:0]      rr_ptr, rr_d, pick;
   logic               last_q, last_d;
   logic               drop;

   // rr_ptr doubles as the owner index while a lock is held
   always_comb begin : rr_search
      int unsigned idx;
      idx  = 0;
      pick = rr_ptr;
      for (int unsigned k = NUM_REQ; k >= 1; k--) begin
         idx = (32'(rr_ptr) + k) % NUM_REQ;
         if (req_valid[PW'(idx)]) pick = PW'(idx);
      end
   end

   always_comb begin : fsm_next
      state_d   = state;
      grant_d   = grant;
      rr_d      = rr_ptr;
      last_d    = last_q;
      req_ready = '0;
      tx_start  = 1'b0;
      tx_data   = '0;
      if (|grant) tx_data = req_data[{rr_ptr, 3'b000} +: 8];
      case (state)
         ARB: begin
            if (!tx_busy && (|req_valid)) begin
               grant_d       = '0;
               grant_d[pick] = 1'b1;
               rr_d          = pick;
               state_d       = LAUNCH;
            end
         end
         LAUNCH: begin
            req_ready[rr_ptr] = req_valid[rr_ptr];
            tx_start          = req_valid[rr_ptr];
            if (req_valid[rr_ptr]) begin
               last_d  = req_last[rr_ptr];
               state_d = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (tx_busy) state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               if (last_q) begin
                  grant_d = '0;
                  state_d = ARB;
               end else begin
                  state_d = LAUNCH;
               end
            end
         end
         default: state_d = ARB;
      endcase
      if (drop) begin
         grant_d = '0;
         state_d = ARB;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ARB;
         grant  <= '0;
         rr_ptr <= PW'(NUM_REQ - 1);
         last_q <= 1'b0;
      end else begin
         state  <= state_d;
         grant  <= grant_d;
         rr_ptr <= rr_d;
         last_q <= last_d;
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);

   logic [TW-1:0] idle_cnt;
   logic          idle;

   // counts cycles the owner leaves the serializer idle mid-packet
   assign idle = (state == LAUNCH) && !req_valid[rr_ptr];
   assign drop = idle && (idle_cnt == TW'(TIMEOUT_CLKS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt      <= '0;
         timeout_pulse <= 1'b0;
      end else begin
         timeout_pulse <= drop;
         idle_cnt      <= (idle && !drop) ? TW'(idle_cnt + 1'b1) : '0;
      end
   end
`else
   assign drop          = 1'b0;
   assign timeout_pulse = 1'b0;
`endif

endmodule
